// File: rtl/hyper_mvblck_frdram_gen.sv
// DRAM-to-LSAB block mover: issues aligned MCU read bursts and raises LSAB write-enables
// for the requested words only, with MCU stall, abort, read-latency pipeline and done pulse.
module hyper_mvblck_frdram_gen #(
   parameter int ADDR_W     = 12,
   parameter int CNT_W      = 5,
   parameter int SEC_W      = 2,
   parameter int RD_LAT     = 2,
   parameter int ALIGN_LOG2 = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [ADDR_W-1:0] START_ADDRESS,
   input  logic [CNT_W-1:0]  COUNT_REQ,
   input  logic [SEC_W-1:0]  SECTION,
   input  logic              ISSUE,
   input  logic              ABORT,
   input  logic              MCU_ACK,
   output logic [ADDR_W-1:0] MCU_COLL_ADDRESS,
   output logic              MCU_REQUEST_ACCESS,
   output logic              LSAB_WRITE,
   output logic [SEC_W-1:0]  LSAB_SECTION,
   output logic              WORKING,
   output logic              DONE,
   output logic [CNT_W-1:0]  COUNT_SENT
);

   localparam int BW = CNT_W + ALIGN_LOG2 + 1;
   localparam logic [BW-1:0]     OFF_MASK = BW'((1 << ALIGN_LOG2) - 1);
   localparam logic [ADDR_W-1:0] ADDR_LOW = ADDR_W'((1 << ALIGN_LOG2) - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t            state_q, state_nxt;
   logic [ADDR_W-1:0] addr_q, addr_nxt;
   logic              req_q, req_nxt;
   logic [SEC_W-1:0]  sec_q, sec_nxt;
   logic [CNT_W-1:0]  sent_q, sent_nxt;
   logic              working_q, working_nxt;
   logic              done_q, done_nxt;
   logic [BW-1:0]     idx_q, idx_nxt;
   logic [BW-1:0]     beats_q, beats_nxt;
   logic [BW-1:0]     off_q, off_nxt;
   logic [BW-1:0]     end_q, end_nxt;
   logic [RD_LAT-1:0] pipe_q, pipe_nxt;

   logic [BW-1:0] off_w, end_w, beats_w;
   logic          accept, push;

   // Word offset inside the first burst, end of the wanted window, and burst-rounded beat count.
   always_comb begin
      off_w   = BW'(START_ADDRESS) & OFF_MASK;
      end_w   = off_w + BW'(COUNT_REQ);
      beats_w = (end_w + OFF_MASK) & ~OFF_MASK;
   end

   assign accept = req_q && MCU_ACK;

   // NOTE: every *_nxt is given its hold value first, so no path leaves one unassigned (no latch).
   always_comb begin
      state_nxt   = state_q;
      addr_nxt    = addr_q;
      req_nxt     = req_q;
      sec_nxt     = sec_q;
      sent_nxt    = sent_q;
      working_nxt = working_q;
      done_nxt    = 1'b0;
      idx_nxt     = idx_q;
      beats_nxt   = beats_q;
      off_nxt     = off_q;
      end_nxt     = end_q;
      push        = 1'b0;

      if (pipe_q[RD_LAT-1] && (sent_q != {CNT_W{1'b1}}))
         sent_nxt = sent_q + 1'b1;

      case (state_q)
         IDLE: begin
            if (ISSUE) begin
               sent_nxt = '0;
               if (COUNT_REQ != '0) begin
                  addr_nxt    = START_ADDRESS & ~ADDR_LOW;
                  sec_nxt     = SECTION;
                  idx_nxt     = '0;
                  off_nxt     = off_w;
                  end_nxt     = end_w;
                  beats_nxt   = beats_w;
                  req_nxt     = 1'b1;
                  working_nxt = 1'b1;
                  state_nxt   = RUN;
               end else begin
                  done_nxt = 1'b1;
               end
            end
         end
         RUN: begin
            if (accept) begin
               addr_nxt = addr_q + 1'b1;
               idx_nxt  = idx_q + 1'b1;
               push     = (idx_q >= off_q) && (idx_q < end_q);
            end
            if ((accept && (idx_q == beats_q - BW'(1))) || ABORT) begin
               req_nxt   = 1'b0;
               state_nxt = DRAIN;
            end
         end
         default: ;
      endcase

      // Shift the valid pipeline; the top bit of the concatenation falls off.
      pipe_nxt = RD_LAT'({pipe_q, push});

      // Finish once no accepted word is still on its way to the LSAB.
      if ((state_q == DRAIN) && (pipe_nxt == '0)) begin
         done_nxt    = 1'b1;
         working_nxt = 1'b0;
         state_nxt   = IDLE;
      end
   end

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         req_q     <= 1'b0;
         sec_q     <= '0;
         sent_q    <= '0;
         working_q <= 1'b0;
         done_q    <= 1'b0;
         idx_q     <= '0;
         beats_q   <= '0;
         off_q     <= '0;
         end_q     <= '0;
         // NOTE: the valid pipeline is cleared too; a stale valid would fire a write after reset.
         pipe_q    <= '0;
      end else begin
         state_q   <= state_nxt;
         addr_q    <= addr_nxt;
         req_q     <= req_nxt;
         sec_q     <= sec_nxt;
         sent_q    <= sent_nxt;
         working_q <= working_nxt;
         done_q    <= done_nxt;
         idx_q     <= idx_nxt;
         beats_q   <= beats_nxt;
         off_q     <= off_nxt;
         end_q     <= end_nxt;
         pipe_q    <= pipe_nxt;
      end
   end

   assign MCU_COLL_ADDRESS   = addr_q;
   assign MCU_REQUEST_ACCESS = req_q;
   assign LSAB_WRITE         = pipe_q[RD_LAT-1];
   assign LSAB_SECTION       = sec_q;
   assign WORKING            = working_q;
   assign DONE               = done_q;
   assign COUNT_SENT         = sent_q;

endmodule

// File: tb/tb_hyper_mvblck_frdram_gen.sv
// Self-checking bench for hyper_mvblck_frdram_gen: table of directed transfers, a reset
// sequence and random transfers, all compared cycle by cycle with a transaction-level model.
module tb_hyper_mvblck_frdram_gen;

   localparam int ADDR_W = 12;
   localparam int CNT_W  = 5;
   localparam int SEC_W  = 2;
   localparam int RD_LAT = 2;
   localparam int ALIGN  = 1;
   localparam int MAXC   = 200;

   logic              CLK = 1'b0;
   logic              RST = 1'b0;
   logic [ADDR_W-1:0] START_ADDRESS = '0;
   logic [CNT_W-1:0]  COUNT_REQ = '0;
   logic [SEC_W-1:0]  SECTION = '0;
   logic              ISSUE = 1'b0;
   logic              ABORT = 1'b0;
   logic              MCU_ACK = 1'b0;
   logic [ADDR_W-1:0] MCU_COLL_ADDRESS;
   logic              MCU_REQUEST_ACCESS;
   logic              LSAB_WRITE;
   logic [SEC_W-1:0]  LSAB_SECTION;
   logic              WORKING;
   logic              DONE;
   logic [CNT_W-1:0]  COUNT_SENT;

   int n_tests = 0;
   int n_fail  = 0;
   int prev_cnt = 0;

   hyper_mvblck_frdram_gen #(
      .ADDR_W(ADDR_W), .CNT_W(CNT_W), .SEC_W(SEC_W), .RD_LAT(RD_LAT), .ALIGN_LOG2(ALIGN)
   ) dut (
      .CLK(CLK), .RST(RST),
      .START_ADDRESS(START_ADDRESS), .COUNT_REQ(COUNT_REQ), .SECTION(SECTION),
      .ISSUE(ISSUE), .ABORT(ABORT), .MCU_ACK(MCU_ACK),
      .MCU_COLL_ADDRESS(MCU_COLL_ADDRESS), .MCU_REQUEST_ACCESS(MCU_REQUEST_ACCESS),
      .LSAB_WRITE(LSAB_WRITE), .LSAB_SECTION(LSAB_SECTION), .WORKING(WORKING),
      .DONE(DONE), .COUNT_SENT(COUNT_SENT)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      string          name;
      logic [11:0]    st;
      logic [4:0]     cnt;
      logic [1:0]     sec;
      logic [127:0]   ack;
      int             abort_c;
      int             reissue_c;
      int             exp_beats;
      int             exp_cnt;
   } vec_t;

   // One transfer: ISSUE in cycle 0, ACK bit c of 'ack' driven in cycle c (cycles past 127 ack).
   // Expected per-cycle behaviour comes from the transfer rules, not from the design's state.
   task automatic run_txn(input string name, input logic [11:0] st, input logic [4:0] cnt,
                          input logic [1:0] sec, input logic [127:0] ack, input int abort_c,
                          input int reissue_c, input int exp_beats, input int exp_cnt);
      bit          ereq [MAXC];
      logic [11:0] eaddr[MAXC];
      bit          ewr  [MAXC];
      int off, nb, k, last, lastwr, d, nwr, nacc, c;
      logic [11:0] base;
      logic        a;
      for (int i = 0; i < MAXC; i++) begin
         ereq[i] = 0; eaddr[i] = '0; ewr[i] = 0;
      end
      off    = int'(st) % (1 << ALIGN);
      nb     = ((off + int'(cnt) + (1 << ALIGN) - 1) >> ALIGN) << ALIGN;
      base   = st - 12'(off);
      k      = 0; last = 0; lastwr = 0; nwr = 0;
      if (cnt == 0) begin
         d = 1;
      end else begin
         for (c = 1; k < nb && c < MAXC - RD_LAT - 3; c++) begin
            a        = (c > 127) ? 1'b1 : ack[c];
            ereq[c]  = 1;
            eaddr[c] = base + 12'(k);
            last     = c;
            if (a) begin
               if (k >= off && k < off + int'(cnt)) begin
                  ewr[c + RD_LAT] = 1;
                  lastwr = c + RD_LAT;
                  nwr++;
               end
               k++;
            end
            if (c == abort_c) break;
         end
         d = (last + 2 > lastwr + 1) ? last + 2 : lastwr + 1;
      end

      @(posedge CLK); #1;
      ISSUE = 1'b1; START_ADDRESS = st; COUNT_REQ = cnt; SECTION = sec;
      MCU_ACK = ack[0]; ABORT = 1'b0;
      @(negedge CLK);
      check($sformatf("%s c0 done", name), 32'(DONE), 32'd0);
      check($sformatf("%s c0 req", name), 32'(MCU_REQUEST_ACCESS), 32'd0);
      check($sformatf("%s c0 count_sent held", name), 32'(COUNT_SENT), 32'(prev_cnt));
      nacc = 0;
      for (int cy = 1; cy <= d; cy++) begin
         @(posedge CLK); #1;
         ISSUE = (cy == reissue_c);
         if (cy == reissue_c) begin
            START_ADDRESS = ~st; COUNT_REQ = cnt + 5'd3; SECTION = ~sec;
         end
         MCU_ACK = (cy > 127) ? 1'b1 : ack[cy];
         ABORT   = (cy == abort_c);
         @(negedge CLK);
         check($sformatf("%s c%0d req", name, cy), 32'(MCU_REQUEST_ACCESS), 32'(ereq[cy]));
         if (ereq[cy])
            check($sformatf("%s c%0d addr", name, cy), 32'(MCU_COLL_ADDRESS), 32'(eaddr[cy]));
         check($sformatf("%s c%0d lsab_write", name, cy), 32'(LSAB_WRITE), 32'(ewr[cy]));
         check($sformatf("%s c%0d done", name, cy), 32'(DONE), 32'(cy == d));
         check($sformatf("%s c%0d working", name, cy), 32'(WORKING),
               32'((cnt != 0) && (cy < d)));
         if (cnt != 0)
            check($sformatf("%s c%0d section", name, cy), 32'(LSAB_SECTION), 32'(sec));
         if (MCU_REQUEST_ACCESS && MCU_ACK) nacc++;
      end
      check($sformatf("%s count_sent at done", name), 32'(COUNT_SENT), 32'(nwr));
      if (exp_cnt >= 0)
         check($sformatf("%s table count_sent", name), 32'(COUNT_SENT), 32'(exp_cnt));
      if (exp_beats >= 0)
         check($sformatf("%s table beats", name), 32'(nacc), 32'(exp_beats));
      ISSUE = 1'b0; ABORT = 1'b0;
      prev_cnt = nwr;
   endtask

   vec_t vecs[9];
   logic [127:0] all_ack;
   logic [127:0] stall_ack;
   logic [127:0] abort_ack;

   initial begin
      all_ack   = '1;
      stall_ack = '1; stall_ack[2] = 1'b0; stall_ack[4] = 1'b0;
      abort_ack = '1; abort_ack[1] = 1'b0;
      vecs[0] = '{"unaligned4",  12'h005, 5'd4,  2'd1, all_ack,   0, 0, 6,  4};
      vecs[1] = '{"wrap4",       12'hFFE, 5'd4,  2'd2, all_ack,   0, 0, 4,  4};
      vecs[2] = '{"stall3",      12'h010, 5'd3,  2'd3, stall_ack, 0, 0, 4,  3};
      vecs[3] = '{"abort16",     12'h020, 5'd16, 2'd0, all_ack,   3, 0, 3,  3};
      vecs[4] = '{"zero",        12'h123, 5'd0,  2'd1, all_ack,   0, 0, 0,  0};
      vecs[5] = '{"single_odd",  12'h007, 5'd1,  2'd3, all_ack,   0, 0, 2,  1};
      vecs[6] = '{"max31",       12'h00A, 5'd31, 2'd2, all_ack,   0, 0, 32, 31};
      vecs[7] = '{"reissue",     12'h040, 5'd5,  2'd1, all_ack,   0, 2, 6,  5};
      vecs[8] = '{"abort_pad",   12'h031, 5'd6,  2'd2, abort_ack, 2, 0, 1,  0};

      RST = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("reset addr", 32'(MCU_COLL_ADDRESS), 32'd0);
      check("reset req", 32'(MCU_REQUEST_ACCESS), 32'd0);
      check("reset write", 32'(LSAB_WRITE), 32'd0);
      check("reset section", 32'(LSAB_SECTION), 32'd0);
      check("reset working", 32'(WORKING), 32'd0);
      check("reset done", 32'(DONE), 32'd0);
      check("reset count_sent", 32'(COUNT_SENT), 32'd0);
      @(posedge CLK); #1;
      RST = 1'b1;

      // Directed table, applied back to back (each ISSUE lands the cycle after the previous DONE).
      for (int i = 0; i < 9; i++)
         run_txn(vecs[i].name, vecs[i].st, vecs[i].cnt, vecs[i].sec, vecs[i].ack,
                 vecs[i].abort_c, vecs[i].reissue_c, vecs[i].exp_beats, vecs[i].exp_cnt);

      // Reset in the middle of a run: everything clears and no DONE follows.
      @(posedge CLK); #1;
      ISSUE = 1'b1; START_ADDRESS = 12'h100; COUNT_REQ = 5'd8; SECTION = 2'd3; MCU_ACK = 1'b1;
      @(posedge CLK); #1;
      ISSUE = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      @(posedge CLK); #1;
      RST = 1'b1;
      check("midreset addr", 32'(MCU_COLL_ADDRESS), 32'd0);
      check("midreset req", 32'(MCU_REQUEST_ACCESS), 32'd0);
      check("midreset write", 32'(LSAB_WRITE), 32'd0);
      check("midreset section", 32'(LSAB_SECTION), 32'd0);
      check("midreset working", 32'(WORKING), 32'd0);
      check("midreset count_sent", 32'(COUNT_SENT), 32'd0);
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         check($sformatf("midreset idle%0d done", i), 32'(DONE), 32'd0);
         check($sformatf("midreset idle%0d write", i), 32'(LSAB_WRITE), 32'd0);
      end
      prev_cnt = 0;
      run_txn("after_reset", 12'h101, 5'd7, 2'd2, all_ack, 0, 0, 8, 7);

      // Random transfers with random stalls and occasional aborts.
      for (int i = 0; i < 30; i++) begin
         logic [127:0] rack;
         int           rab;
         rack = {$urandom, $urandom, $urandom, $urandom} | {$urandom, $urandom, $urandom, $urandom};
         rab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 0;
         run_txn($sformatf("rand%0d", i), 12'($urandom_range(0, 4095)),
                 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), rack, rab, 0, -1, -1);
         repeat ($urandom_range(0, 2)) @(posedge CLK);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
